// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared widths, VGA 640x480 default timing and the colour-bar table.
package video_timing_pkg;

   localparam int CNT_W = 12;

   localparam int VGA640_H_ACTIVE = 640;
   localparam int VGA640_H_FP     = 16;
   localparam int VGA640_H_SYNC   = 96;
   localparam int VGA640_H_BP     = 48;
   localparam int VGA640_V_ACTIVE = 480;
   localparam int VGA640_V_FP     = 10;
   localparam int VGA640_V_SYNC   = 2;
   localparam int VGA640_V_BP     = 33;
   localparam int VGA640_CE_DIV   = 2;

   typedef logic [23:0] rgb_t;

   // Eight vertical bars, left to right.
   localparam rgb_t COLOUR_BARS [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   function automatic rgb_t bar_colour(input logic [2:0] idx);
      return COLOUR_BARS[idx];
   endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis (horizontal or vertical). Counts 0..TOTAL-1 on
// step, clears on clr, and decodes the active and sync windows from the count.
module vtg_axis_counter
   import video_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             step,
   output logic [CNT_W-1:0] cnt,
   output logic             active,
   output logic             sync,
   output logic             wrap
);

   localparam int TOTAL = ACTIVE + FP + SYNC + BP;

   // Window edges are one bit wider than the counter so a window ending exactly
   // at 4096 still compares correctly.
   localparam logic [CNT_W:0]   ACT_END    = (CNT_W+1)'(ACTIVE);
   localparam logic [CNT_W:0]   SYNC_START = (CNT_W+1)'(ACTIVE + FP);
   localparam logic [CNT_W:0]   SYNC_END   = (CNT_W+1)'(ACTIVE + FP + SYNC);
   localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);

   if (TOTAL > (1 << CNT_W) || TOTAL < 1) begin : g_bad_total
      $error("vtg_axis_counter: total of %0d does not fit a %0d-bit counter", TOTAL, CNT_W);
   end

   logic [CNT_W:0] cnt_ext;

   assign cnt_ext = {1'b0, cnt};
   assign active  = (cnt_ext < ACT_END);
   assign sync    = (cnt_ext >= SYNC_START) && (cnt_ext < SYNC_END);
   assign wrap    = (cnt == LAST);

   // Position counter: clear wins over step; wraps to 0 after the last position.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing with pixel clock-enable, coordinate
// outputs and a fully registered 24-bit RGB stream (zero outside active video).
// Optional macro VTG_TESTPAT_EN replaces din with an internal 8-bar colour pattern.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA640_H_ACTIVE,
   parameter int H_FP     = VGA640_H_FP,
   parameter int H_SYNC   = VGA640_H_SYNC,
   parameter int H_BP     = VGA640_H_BP,
   parameter int V_ACTIVE = VGA640_V_ACTIVE,
   parameter int V_FP     = VGA640_V_FP,
   parameter int V_SYNC   = VGA640_V_SYNC,
   parameter int V_BP     = VGA640_V_BP,
   parameter int CE_DIV   = VGA640_CE_DIV
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [23:0]      din,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   output logic [23:0]      dout,
   output logic             hs_out,
   output logic             vs_out,
   output logic             de_out,
   output logic             ce_out,
   output logic             frame_start
);

   localparam int             CE_W    = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
   localparam logic [CE_W-1:0] CE_LAST = CE_W'(CE_DIV - 1);

   if (CE_DIV < 1) begin : g_bad_ce_div
      $error("video_timing_gen: CE_DIV must be at least 1, got %0d", CE_DIV);
   end

   logic [CE_W-1:0]  cediv;
   logic             ce_int;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_act;
   logic             h_sync;
   logic             h_wrap;
   logic             v_act;
   logic             v_sync;
   logic             v_wrap_unused;
   logic             v_step;
   logic [23:0]      pixel;

   // Pixel divider: free-runs 0..CE_DIV-1 while enabled, parked at 0 otherwise so
   // the first enabled cycle is always a pixel cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cediv <= '0;
      end else if (!enable || cediv == CE_LAST) begin
         cediv <= '0;
      end else begin
         cediv <= cediv + CE_W'(1);
      end
   end

   assign ce_int = enable && (cediv == '0);
   assign v_step = ce_int && h_wrap;

   vtg_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!enable),
      .step   (ce_int),
      .cnt    (h_cnt),
      .active (h_act),
      .sync   (h_sync),
      .wrap   (h_wrap)
   );

   // Vertical axis only moves on the line wrap, so vsync is line-aligned.
   vtg_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_axis (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!enable),
      .step   (v_step),
      .cnt    (v_cnt),
      .active (v_act),
      .sync   (v_sync),
      .wrap   (v_wrap_unused)
   );

   assign pix_x = h_cnt;
   assign pix_y = v_cnt;

`ifdef VTG_TESTPAT_EN
   // Bars are H_ACTIVE/8 wide; a narrower-than-8 line degrades to one pixel per bar.
   localparam int               BAR_W    = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;
   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

   logic [CNT_W-1:0] bar_px;
   logic [2:0]       bar_idx;
   logic             din_unused;

   // Bar position tracker: restarts with each line and whenever timing is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (!enable || (ce_int && h_wrap)) begin
         bar_px  <= '0;
         bar_idx <= '0;
      end else if (ce_int) begin
         if (bar_px == BAR_LAST) begin
            bar_px  <= '0;
            bar_idx <= bar_idx + 3'd1;
         end else begin
            bar_px  <= bar_px + CNT_W'(1);
         end
      end
   end

   assign pixel      = bar_colour(bar_idx);
   assign din_unused = ^din;
`else
   assign pixel = din;
`endif

   // Output stage. Strobes (ce_out, frame_start) follow every clk; the video
   // signals load only on pixel cycles so they change only where ce_out is high,
   // and clear on the clk after enable drops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_out      <= 1'b0;
         frame_start <= 1'b0;
         de_out      <= 1'b0;
         hs_out      <= 1'b0;
         vs_out      <= 1'b0;
         dout        <= '0;
      end else begin
         ce_out      <= ce_int;
         frame_start <= ce_int && (h_cnt == '0) && (v_cnt == '0);
         if (!enable) begin
            de_out <= 1'b0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            dout   <= '0;
         end else if (ce_int) begin
            de_out <= h_act && v_act;
            hs_out <= h_sync;
            vs_out <= v_sync;
            dout   <= (h_act && v_act) ? pixel : '0;
         end
      end
   end

endmodule
